vga_display: RTL



---
 rtl/vga_display.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vga_display.sv
// Pixel source for the VGA timing driver: static border frame plus a bouncing
// square block, returned as registered 12-bit RGB one cycle after the request.
module vga_display #(
   parameter int          H_DISP    = 640,
   parameter int          V_DISP    = 480,
   parameter int          BORDER_W  = 10,
   parameter int          BLOCK_W   = 40,
   parameter int          STEP      = 2,
   parameter int          FRAME_DIV = 2,
   parameter logic [11:0] C_BORDER  = 12'hFFF,
   parameter logic [11:0] C_BLOCK   = 12'h00F,
   parameter logic [11:0] C_BACK    = 12'h000
) (
   input  logic        vga_clk,
   input  logic        sys_rst_n,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        move_en,
   output logic [11:0] pixel_data
);

   localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

   localparam logic [10:0] X_MIN  = 11'(BORDER_W);
   localparam logic [10:0] X_MAX  = 11'(H_DISP - BORDER_W - BLOCK_W);
   localparam logic [10:0] Y_MIN  = 11'(BORDER_W + 1);
   localparam logic [10:0] Y_MAX  = 11'(V_DISP - BORDER_W - BLOCK_W + 1);
   localparam logic [10:0] STEP_V = 11'(STEP);
   localparam logic [10:0] BLK_V  = 11'(BLOCK_W);

   typedef enum logic {DIR_INC, DIR_DEC} dir_t;

   logic [10:0]      block_x, block_y;
   logic [10:0]      next_x, next_y;
   dir_t             dir_x, dir_y;
   dir_t             next_dir_x, next_dir_y;
   logic [CNT_W-1:0] frame_cnt;
   logic [10:0]      px, py;
   logic             is_border, is_block, frame_end, update;
   logic [11:0]      colour;

   assign px = {1'b0, pixel_x};
   assign py = {1'b0, pixel_y};

   assign is_border = (px < 11'(BORDER_W)) || (px >= 11'(H_DISP - BORDER_W)) ||
                      (py <= 11'(BORDER_W)) || (py > 11'(V_DISP - BORDER_W));
   assign is_block  = (px >= block_x) && (px < block_x + BLK_V) &&
                      (py >= block_y) && (py < block_y + BLK_V);

   always_comb begin
      colour = C_BACK;
      if (is_border)
         colour = C_BORDER;
      else if (is_block)
         colour = C_BLOCK;
   end

   // Last active pixel of the frame; rows are numbered 1..V_DISP.
   assign frame_end = (pixel_x == 10'(H_DISP - 1)) && (pixel_y == 10'(V_DISP));
   assign update    = frame_end && move_en && (frame_cnt == CNT_LAST);

   // Each axis clamps to its limit and reverses when the next step would overshoot.
   always_comb begin
      next_x     = block_x;
      next_dir_x = dir_x;
      if (dir_x == DIR_INC) begin
         if (block_x + STEP_V > X_MAX) begin
            next_x     = X_MAX;
            next_dir_x = DIR_DEC;
         end else begin
            next_x = block_x + STEP_V;
         end
      end else begin
         if (block_x < X_MIN + STEP_V) begin
            next_x     = X_MIN;
            next_dir_x = DIR_INC;
         end else begin
            next_x = block_x - STEP_V;
         end
      end
   end

   always_comb begin
      next_y     = block_y;
      next_dir_y = dir_y;
      if (dir_y == DIR_INC) begin
         if (block_y + STEP_V > Y_MAX) begin
            next_y     = Y_MAX;
            next_dir_y = DIR_DEC;
         end else begin
            next_y = block_y + STEP_V;
         end
      end else begin
         if (block_y < Y_MIN + STEP_V) begin
            next_y     = Y_MIN;
            next_dir_y = DIR_INC;
         end else begin
            next_y = block_y - STEP_V;
         end
      end
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pixel_data <= 12'h000;
         block_x    <= X_MIN;
         block_y    <= Y_MIN;
         dir_x      <= DIR_INC;
         dir_y      <= DIR_INC;
         frame_cnt  <= '0;
      end else begin
         pixel_data <= colour;
         if (frame_end && move_en) begin
            if (frame_cnt == CNT_LAST)
               frame_cnt <= '0;
            else
               frame_cnt <= frame_cnt + 1'b1;
         end
         if (update) begin
            block_x <= next_x;
            block_y <= next_y;
            dir_x   <= next_dir_x;
            dir_y   <= next_dir_y;
         end
      end
   end

endmodule
